// File: rtl/subpel_row_sequencer.sv
// rtl/subpel_row_sequencer.sv - vertical-pass row sequencer for the HEVC sub-pel interpolation datapath
// Optional feature macro: SUBPEL_STALL_EN (adds the dp_stall input that pauses row issue).
module subpel_row_sequencer #(
  parameter int NUM_ROWS = 15,
  parameter int TAPS     = 8,
  parameter int ADDR_W   = 4,
  parameter int DP_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        frac_y,
`ifdef SUBPEL_STALL_EN
  input  logic              dp_stall,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              dp_load,
  output logic              dp_fire,
  output logic [1:0]        dp_sel,
  output logic              dp_bypass,
  output logic              out_valid,
  output logic [2:0]        out_row,
  output logic              busy,
  output logic              done
);

  // Filtered blocks walk the whole row store; integer (bypass) blocks only
  // need the eight rows centred under the filter, starting one above centre.
  localparam logic [ADDR_W-1:0] FILT_FIRST = '0;
  localparam logic [ADDR_W-1:0] FILT_LAST  = ADDR_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] BYP_FIRST  = ADDR_W'(TAPS / 2 - 1);
  localparam logic [ADDR_W-1:0] BYP_LAST   = ADDR_W'(TAPS / 2 + 6);
  // Row index whose load completes the 8-tap window (load number TAPS).
  localparam logic [ADDR_W-1:0] FIRE_FROM  = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_addr;
  logic [1:0]        sel_q;
  logic              byp_q;
  logic              load_q;
  logic              fire_q;
  logic [DP_LAT-1:0] vpipe_q;
  logic [2:0]        row_q;
  logic              issue;
  logic              stall;
  logic              accept;
  logic              last_out;

`ifdef SUBPEL_STALL_EN
  assign stall = dp_stall;
`else
  assign stall = 1'b0;
`endif

  assign accept    = (state_q == S_IDLE) && start;
  assign last_addr = byp_q ? BYP_LAST : FILT_LAST;
  assign last_out  = vpipe_q[DP_LAT-1] && (row_q == 3'd7);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the state-decoded strobes (read issue, busy, done).
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy  = 1'b1;
        issue = !stall;
        if (issue && (addr_q == last_addr)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (last_out) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Phase capture: frac_y is latched only when a block is accepted so that
  // the datapath coefficients cannot change underneath a running block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 2'd0;
      byp_q <= 1'b0;
    end else if (accept) begin
      sel_q <= frac_y;
      byp_q <= (frac_y == 2'd0);
    end
  end

  // Issue counter: loaded with the mode's first row on accept, advanced on
  // every issued read, and parked on the last row so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= (frac_y == 2'd0) ? BYP_FIRST : FILT_FIRST;
    end else if (issue && (addr_q != last_addr)) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Load/fire pipeline: the store answers one cycle after a read, so each
  // issued read becomes a load one cycle later; a fire rides along with the
  // load that completes the window (every load in bypass mode).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      load_q <= issue;
      fire_q <= issue && (byp_q || (addr_q >= FIRE_FROM));
    end
  end

  // Datapath latency model: out_valid is dp_fire delayed by DP_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe_q <= '0;
    end else begin
      for (int i = DP_LAT - 1; i > 0; i--) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
      vpipe_q[0] <= fire_q;
    end
  end

  // Output row index: advances after each valid row, wrapping 7 -> 0, so it
  // is back at 0 when the block completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= 3'd0;
    end else if (vpipe_q[DP_LAT-1]) begin
      row_q <= row_q + 3'd1;
    end
  end

  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign dp_load   = load_q;
  assign dp_fire   = fire_q;
  assign dp_sel    = sel_q;
  assign dp_bypass = byp_q;
  assign out_valid = vpipe_q[DP_LAT-1];
  assign out_row   = row_q;

endmodule

// File: tb/tb_subpel_row_sequencer.sv
// tb/tb_subpel_row_sequencer.sv - randomized model-checked bench for subpel_row_sequencer (DP_LAT 1 and 3)
module tb_subpel_row_sequencer;

  localparam int NCYC = 2500;
  localparam int NA   = NCYC + 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] frac_y;
`ifdef SUBPEL_STALL_EN
  logic       dp_stall;
`endif

  logic       rd_en_o     [2];
  logic [3:0] rd_addr_o   [2];
  logic       dp_load_o   [2];
  logic       dp_fire_o   [2];
  logic [1:0] dp_sel_o    [2];
  logic       dp_bypass_o [2];
  logic       out_valid_o [2];
  logic [2:0] out_row_o   [2];
  logic       busy_o      [2];
  logic       done_o      [2];

  int tests_run    = 0;
  int tests_failed = 0;

  int lat [2] = '{1, 3};

  // Stimulus tables, indexed by the interval following clock edge t.
  bit         start_at [NA];
  bit         rst_at   [NA];
  bit         stall_at [NA];
  logic [1:0] frac_at  [NA];

  // Expected outputs per instance per interval.
  bit e_rd   [2][NA];
  int e_addr [2][NA];
  bit e_ld   [2][NA];
  bit e_fi   [2][NA];
  bit e_ov   [2][NA];
  int e_row  [2][NA];
  bit e_busy [2][NA];
  bit e_done [2][NA];
  int e_sel  [2][NA];
  bit e_byp  [2][NA];
  int free_from [2];

  always #5 clk = ~clk;

  subpel_row_sequencer #(.DP_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .start(start), .frac_y(frac_y),
`ifdef SUBPEL_STALL_EN
    .dp_stall(dp_stall),
`endif
    .rd_en(rd_en_o[0]), .rd_addr(rd_addr_o[0]), .dp_load(dp_load_o[0]),
    .dp_fire(dp_fire_o[0]), .dp_sel(dp_sel_o[0]), .dp_bypass(dp_bypass_o[0]),
    .out_valid(out_valid_o[0]), .out_row(out_row_o[0]), .busy(busy_o[0]),
    .done(done_o[0])
  );

  subpel_row_sequencer #(.DP_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .start(start), .frac_y(frac_y),
`ifdef SUBPEL_STALL_EN
    .dp_stall(dp_stall),
`endif
    .rd_en(rd_en_o[1]), .rd_addr(rd_addr_o[1]), .dp_load(dp_load_o[1]),
    .dp_fire(dp_fire_o[1]), .dp_sel(dp_sel_o[1]), .dp_bypass(dp_bypass_o[1]),
    .out_valid(out_valid_o[1]), .out_row(out_row_o[1]), .busy(busy_o[1]),
    .done(done_o[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Block accepted at edge e: walk the issue list, skipping stalled
  // intervals, and place each load, fire, valid row and the done pulse.
  task automatic schedule(input int k, input int e, input int f);
    int n_issue;
    int base;
    int t;
    int n;
    int nv;
    int last_v;
    n_issue = (f == 0) ? 8 : 15;
    base    = (f == 0) ? 3 : 0;
    t = e; n = 0; nv = 0; last_v = e;
    while (n < n_issue && t < NA - 8) begin
      if (!stall_at[t]) begin
        e_rd[k][t]   = 1'b1;
        e_addr[k][t] = base + n;
        e_ld[k][t+1] = 1'b1;
        if (f == 0 || n + 1 >= 8) begin
          e_fi[k][t+1] = 1'b1;
          e_ov[k][t+1+lat[k]]  = 1'b1;
          e_row[k][t+1+lat[k]] = nv;
          nv++;
          last_v = t + 1 + lat[k];
        end
        n++;
      end
      t++;
    end
    for (int i = e; i <= last_v; i++) e_busy[k][i] = 1'b1;
    e_done[k][last_v+1] = 1'b1;
    free_from[k] = last_v + 2;
    for (int i = e; i < NA; i++) begin
      e_sel[k][i] = f;
      e_byp[k][i] = (f == 0);
    end
  endtask

  task automatic model_reset(input int k, input int t);
    for (int i = t; i < NA; i++) begin
      e_rd[k][i] = 0; e_addr[k][i] = 0; e_ld[k][i] = 0; e_fi[k][i] = 0;
      e_ov[k][i] = 0; e_row[k][i] = 0; e_busy[k][i] = 0; e_done[k][i] = 0;
      e_sel[k][i] = 0; e_byp[k][i] = 0;
    end
    free_from[k] = t;
  endtask

  task automatic check_zero(input int k, input string when);
    string p;
    p = $sformatf("L%0d %s", lat[k], when);
    check({p, " rd_en"},     int'(rd_en_o[k]),     0);
    check({p, " rd_addr"},   int'(rd_addr_o[k]),   0);
    check({p, " dp_load"},   int'(dp_load_o[k]),   0);
    check({p, " dp_fire"},   int'(dp_fire_o[k]),   0);
    check({p, " dp_sel"},    int'(dp_sel_o[k]),    0);
    check({p, " dp_bypass"}, int'(dp_bypass_o[k]), 0);
    check({p, " out_valid"}, int'(out_valid_o[k]), 0);
    check({p, " out_row"},   int'(out_row_o[k]),   0);
    check({p, " busy"},      int'(busy_o[k]),      0);
    check({p, " done"},      int'(done_o[k]),      0);
  endtask

  task automatic compare_cycle(input int k, input int t);
    string p;
    p = $sformatf("L%0d t%0d", lat[k], t);
    check({p, " rd_en"}, int'(rd_en_o[k]), int'(e_rd[k][t]));
    if (e_rd[k][t]) check({p, " rd_addr"}, int'(rd_addr_o[k]), e_addr[k][t]);
    check({p, " dp_load"},   int'(dp_load_o[k]),   int'(e_ld[k][t]));
    check({p, " dp_fire"},   int'(dp_fire_o[k]),   int'(e_fi[k][t]));
    check({p, " dp_sel"},    int'(dp_sel_o[k]),    e_sel[k][t]);
    check({p, " dp_bypass"}, int'(dp_bypass_o[k]), int'(e_byp[k][t]));
    check({p, " out_valid"}, int'(out_valid_o[k]), int'(e_ov[k][t]));
    if (e_ov[k][t]) check({p, " out_row"}, int'(out_row_o[k]), e_row[k][t]);
    check({p, " busy"}, int'(busy_o[k]), int'(e_busy[k][t]));
    check({p, " done"}, int'(done_o[k]), int'(e_done[k][t]));
  endtask

  initial begin
    for (int i = 0; i < NA; i++) begin
      start_at[i] = 0; rst_at[i] = 0; stall_at[i] = 0;
      frac_at[i]  = 2'($urandom_range(0, 3));
    end
    for (int k = 0; k < 2; k++) model_reset(k, 0);

    // Filtered block reset mid-fetch, then a full filtered block.
    start_at[2] = 1; frac_at[2] = 2'd2;
    rst_at[8] = 1;
    start_at[12] = 1; frac_at[12] = 2'd2;
    // Bypass block.
    start_at[40] = 1; frac_at[40] = 2'd0;
    // Starts and phase changes while busy must be ignored.
    start_at[60] = 1; frac_at[60] = 2'd3;
    for (int i = 61; i < 75; i++) frac_at[i] = 2'd1;
    start_at[65] = 1; start_at[72] = 1;
    // Filtered block, frac 1, with a three-cycle stall early in the fetch.
    start_at[90] = 1; frac_at[90] = 2'd1;
`ifdef SUBPEL_STALL_EN
    stall_at[94] = 1; stall_at[95] = 1; stall_at[96] = 1;
`endif
    // Randomized traffic.
    for (int i = 120; i < NCYC - 100; i++) begin
      start_at[i] = ($urandom_range(0, 7) == 0);
      rst_at[i]   = ($urandom_range(0, 299) == 0);
`ifdef SUBPEL_STALL_EN
      stall_at[i] = ($urandom_range(0, 3) == 0);
`endif
    end

    rst = 1'b1; start = 1'b0; frac_y = 2'd0;
`ifdef SUBPEL_STALL_EN
    dp_stall = 1'b0;
`endif
    #2;
    for (int k = 0; k < 2; k++) check_zero(k, "reset");
    #1 rst = 1'b0;

    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      if (t > 0) begin
        for (int k = 0; k < 2; k++) begin
          if (start_at[t-1] && (t - 1) >= free_from[k]) schedule(k, t, int'(frac_at[t-1]));
        end
      end
      #1;
      start  = start_at[t];
      frac_y = frac_at[t];
`ifdef SUBPEL_STALL_EN
      dp_stall = stall_at[t];
`endif
      if (rst_at[t]) begin
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check_zero(k, $sformatf("rst t%0d", t));
        rst = 1'b0;
        for (int k = 0; k < 2; k++) model_reset(k, t);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) compare_cycle(k, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
